addsub_serial: RTL and testbench

ADDSUB_SERIAL -- requirements
Module: addsub_serial

---
 rtl/addsub_pkg.sv | 21 ++
 rtl/addsub_chunk.sv | 40 ++++
 rtl/addsub_serial.sv | 138 +++++++++++++
 tb/tb_addsub_serial.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg -- shared types and encodings for the serial adder/subtractor.
//   state_t    : controller states IDLE / BUSY / DONE
//   OP_ADD/SUB : encodings of the op input
//   slice0_cin : carry fed into the first (LSB) slice
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Subtract is A + ~B + ~borrow_in, so the LSB slice sees cin inverted.
   function automatic logic slice0_cin(input logic op, input logic cin);
      return (op == OP_ADD) ? cin : ~cin;
   endfunction

endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk -- combinational CHUNK-bit ripple slice of full adders.
//   a, b    : slice operands
//   op      : OP_SUB inverts b
//   cin     : slice carry-in
//   sum     : slice sum
//   cout    : carry out of the slice MSB
//   msb_cin : carry into the slice MSB (used for signed overflow)
module addsub_chunk
   import addsub_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             op,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             msb_cin
);

   logic [CHUNK-1:0] b_eff;
   logic [CHUNK:0]   c;

   assign b_eff = (op == OP_SUB) ? ~b : b;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         sum[i]   = a[i] ^ b_eff[i] ^ c[i];
         c[i+1]   = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
      end
   end

   assign cout    = c[CHUNK];
   assign msb_cin = c[CHUNK-1];

endmodule

// File: rtl/addsub_serial.sv
// addsub_serial -- bit-serial (CHUNK bits per cycle) adder/subtractor with
// valid/ready handshakes on both sides.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, op, cin captured on accept)
//   out_valid/out_ready : result handshake (result, carry, overflow, zero)
//   sat_mode            : only with ADDSUB_SERIAL_SAT_EN defined; clamps the
//                         result to signed max/min on overflow
// Without ADDSUB_SERIAL_SAT_EN the result always wraps modulo 2^WIDTH.
// Latency: out_valid rises WIDTH/CHUNK cycles after the accepting edge.
module addsub_serial
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   input  logic             cin,
`ifdef ADDSUB_SERIAL_SAT_EN
   input  logic             sat_mode,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int NSLICE = WIDTH / CHUNK;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [WIDTH-1:0] SMIN = WIDTH'(1) << (WIDTH - 1);
   localparam logic [WIDTH-1:0] SMAX = ~SMIN;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nx, fin;
   logic [CHUNK-1:0] sum_s;
   logic             op_q, cy_q, sat_q;
   logic             cout_s, mcin_s, ovf;
   logic [CW-1:0]    cnt_q;
   logic             accept, last;

   assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
   assign accept    = in_valid && in_ready;
   assign last      = (cnt_q == CW'(NSLICE - 1));
   assign out_valid = (state == DONE);

   // ---------------- controller ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = BUSY;
         BUSY: if (last)   state_nx = DONE;
         DONE: if (out_ready) state_nx = accept ? BUSY : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a       (a_q[CHUNK-1:0]),
      .b       (b_q[CHUNK-1:0]),
      .op      (op_q),
      .cin     (cy_q),
      .sum     (sum_s),
      .cout    (cout_s),
      .msb_cin (mcin_s)
   );

   // Slices enter at the top and shift down; after NSLICE slices the
   // first one sits in the LSBs. Concatenate-then-shift stays legal when
   // CHUNK == WIDTH.
   assign acc_nx = WIDTH'({sum_s, acc_q} >> CHUNK);
   assign ovf    = cout_s ^ mcin_s;

   // On overflow the wrapped MSB is the inverse of the true sign:
   // MSB 1 means the true result was positive.
   always_comb begin
      fin = acc_nx;
      if (sat_q && ovf) fin = acc_nx[WIDTH-1] ? SMAX : SMIN;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         op_q     <= 1'b0;
         cy_q     <= 1'b0;
         cnt_q    <= '0;
         result   <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else if (accept) begin
         a_q   <= a;
         b_q   <= b;
         acc_q <= '0;
         op_q  <= op;
         cy_q  <= slice0_cin(op, cin);
         cnt_q <= '0;
      end else if (state == BUSY) begin
         a_q   <= a_q >> CHUNK;
         b_q   <= b_q >> CHUNK;
         acc_q <= acc_nx;
         cy_q  <= cout_s;
         cnt_q <= cnt_q + CW'(1);
         // Output registers only move on the final slice, so they hold
         // through DONE and across a back-to-back accept.
         if (last) begin
            result   <= fin;
            carry    <= cout_s;
            overflow <= ovf;
            zero     <= (fin == '0);
         end
      end
   end

`ifdef ADDSUB_SERIAL_SAT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         sat_q <= 1'b0;
      else if (accept) sat_q <= sat_mode;
   end
`else
   assign sat_q = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial -- directed scoreboard bench for addsub_serial
// (WIDTH=16, CHUNK=4). Driver pushes hand-computed expectations on accept;
// a monitor pops and compares whenever out_valid is presented.
// Saturation vectors are included when ADDSUB_SERIAL_SAT_EN is defined.
module tb_addsub_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [15:0] a, b;
   logic        op, cin;
`ifdef ADDSUB_SERIAL_SAT_EN
   logic        sat_mode;
`endif
   logic        out_valid, out_ready;
   logic [15:0] result;
   logic        carry, overflow, zero;

   typedef struct {
      logic [15:0] res;
      logic        c, v, z;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic seen  = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   addsub_serial #(.WIDTH(16), .CHUNK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .cin       (cin),
`ifdef ADDSUB_SERIAL_SAT_EN
      .sat_mode  (sat_mode),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Monitor: sample 2 time units after the falling edge so driver updates
   // made on that edge have settled.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (rst) begin
         seen = 1'b0;
      end else if (out_valid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_valid", 32'(out_valid), 32'd0);
         end else begin
            e = exp_q[0];
            if (!seen) begin
               chk("latency", 32'(cyc - e.acc), 32'd4);
               seen = 1'b1;
            end
            chk("result", 32'(result), 32'(e.res));
            chk("flags_cvz", 32'({carry, overflow, zero}), 32'({e.c, e.v, e.z}));
            if (out_ready) begin
               void'(exp_q.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   // Call on a falling edge; returns on the falling edge after acceptance.
   task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic top,
                       input logic tcin, input logic [15:0] er, input logic ec,
                       input logic ev, input logic ez);
      int n;
      a = ta; b = tb_v; op = top; cin = tcin; in_valid = 1'b1;
      n = 0;
      #1;
      while (!in_ready && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
      exp_q.push_back('{er, ec, ev, ez, cyc + 1});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk(name, 32'(exp_q.size()), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int n;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; cin = 1'b0;
      out_ready = 1'b1;
`ifdef ADDSUB_SERIAL_SAT_EN
      sat_mode = 1'b0;
`endif
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_outputs", 32'({result, carry, overflow, zero}), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // basic arithmetic, back-to-back with out_ready high
      send(16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0);
      send(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      send(16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
      send(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0);
      send(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      send(16'h0003, 16'h0003, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      drain("drain_basic");

      // backpressure: hold out_ready low 3 cycles in DONE
      out_ready = 1'b0;
      send(16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid_seen", 32'(out_valid), 32'd1);
      repeat (3) begin
         @(negedge clk);
         #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      send(16'h1000, 16'h2000, 1'b1, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b0);
      drain("drain_bp");

      // reset mid-operation
      send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_outputs", 32'({result, carry, overflow, zero}), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 chk("rel_in_ready", 32'(in_ready), 32'd1);
      send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
      drain("drain_rst");

`ifdef ADDSUB_SERIAL_SAT_EN
      sat_mode = 1'b1;
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      send(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
      send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
      drain("drain_sat");
      sat_mode = 1'b0;
`endif

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
